// File: rtl/noc_vc_credit_arbiter.sv
// Per-output-link VC arbiter for the credit-based BFT router: round-robin grant
// among requesting VCs that hold credit, one credit counter per downstream VC FIFO.
module noc_vc_credit_arbiter #(
  parameter int VC_W          = 2,
  parameter int VC_FIFO_DEPTH = 32,
  parameter int COUNTER_W     = $clog2(VC_FIFO_DEPTH)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [VC_W-1:0]           i_req,
  output logic [VC_W-1:0]           o_grant,
  output logic                      o_valid,
  input  logic                      i_accept,
  input  logic [VC_W-1:0]           i_credit_ret,
  output logic [VC_W*COUNTER_W-1:0] o_credits,
  output logic                      o_overflow
);

  localparam int PTR_W = (VC_W > 1) ? $clog2(VC_W) : 1;
  localparam logic [COUNTER_W-1:0] MAX_CRED = COUNTER_W'(VC_FIFO_DEPTH - 1);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t               state_q, state_d;
  logic [VC_W-1:0]      grant_q, grant_d;
  logic [PTR_W-1:0]     gidx_q, gidx_d;
  logic [PTR_W-1:0]     ptr_q, ptr_d;
  logic [COUNTER_W-1:0] cred_q [VC_W];
  logic [COUNTER_W-1:0] cred_d [VC_W];
  logic                 ovf_q, ovf_d;

  logic                 fire;
  logic [VC_W-1:0]      dec_vec;
  logic [VC_W-1:0]      elig;
  logic                 win_found;
  logic [PTR_W-1:0]     win_idx;

  function automatic logic [PTR_W-1:0] wrap_inc(input logic [PTR_W-1:0] p);
    if (int'(p) == VC_W - 1) return '0;
    return p + PTR_W'(1);
  endfunction

  // Returns {found, index} of the first set bit scanning upward from ptr with wrap.
  function automatic logic [PTR_W:0] pick(input logic [VC_W-1:0] e,
                                          input logic [PTR_W-1:0] ptr);
    logic [PTR_W-1:0] idx;
    logic [PTR_W-1:0] sel;
    logic             found;
    idx   = ptr;
    sel   = '0;
    found = 1'b0;
    for (int i = 0; i < VC_W; i++) begin
      if (!found && e[idx]) begin
        found = 1'b1;
        sel   = idx;
      end
      idx = wrap_inc(idx);
    end
    return {found, sel};
  endfunction

  assign fire    = (state_q == GRANT) && i_accept;
  assign dec_vec = fire ? grant_q : '0;

  always_comb begin
    ovf_d = ovf_q;
    elig  = '0;
    for (int v = 0; v < VC_W; v++) begin
      cred_d[v] = cred_q[v];
      if (dec_vec[v] && !i_credit_ret[v]) begin
        cred_d[v] = cred_q[v] - COUNTER_W'(1);
      end else if (i_credit_ret[v] && !dec_vec[v]) begin
        if (cred_q[v] == MAX_CRED) ovf_d = 1'b1;
        else                       cred_d[v] = cred_q[v] + COUNTER_W'(1);
      end
      // Eligibility sees this cycle's credit update so a same-cycle return can grant.
      elig[v] = i_req[v] && (cred_d[v] != '0);
    end
  end

  always_comb begin
    ptr_d     = fire ? wrap_inc(gidx_q) : ptr_q;
    state_d   = state_q;
    grant_d   = grant_q;
    gidx_d    = gidx_q;
    {win_found, win_idx} = pick(elig, ptr_d);
    if (state_q == IDLE || fire) begin
      if (win_found) begin
        state_d = GRANT;
        grant_d = VC_W'(1) << win_idx;
        gidx_d  = win_idx;
      end else begin
        state_d = IDLE;
        grant_d = '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      grant_q <= '0;
      gidx_q  <= '0;
      ptr_q   <= '0;
      ovf_q   <= 1'b0;
      for (int v = 0; v < VC_W; v++) cred_q[v] <= MAX_CRED;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      gidx_q  <= gidx_d;
      ptr_q   <= ptr_d;
      ovf_q   <= ovf_d;
      for (int v = 0; v < VC_W; v++) cred_q[v] <= cred_d[v];
    end
  end

  assign o_valid    = (state_q == GRANT);
  assign o_grant    = grant_q;
  assign o_overflow = ovf_q;

  always_comb begin
    o_credits = '0;
    for (int v = 0; v < VC_W; v++) o_credits[v*COUNTER_W +: COUNTER_W] = cred_q[v];
  end

endmodule

// File: tb/tb_noc_vc_credit_arbiter.sv
// Bench for noc_vc_credit_arbiter: vector table plus drain/refill sequence,
// expectations queued at drive time and compared one cycle later.
module tb_noc_vc_credit_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] i_req;
  logic [1:0] o_grant;
  logic       o_valid;
  logic       i_accept;
  logic [1:0] i_credit_ret;
  logic [9:0] o_credits;
  logic       o_overflow;

  int checks = 0;
  int errors = 0;

  noc_vc_credit_arbiter #(.VC_W(2), .VC_FIFO_DEPTH(32)) dut (
    .clk(clk), .rst(rst), .i_req(i_req), .o_grant(o_grant), .o_valid(o_valid),
    .i_accept(i_accept), .i_credit_ret(i_credit_ret), .o_credits(o_credits),
    .o_overflow(o_overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic [1:0] req;
    logic       acc;
    logic [1:0] ret;
    logic       v;
    logic [1:0] g;
    logic [4:0] c0;
    logic [4:0] c1;
    logic       ovf;
  } vec_t;

  vec_t tbl[$];
  vec_t sb[$];

  function automatic vec_t mk(input logic r, input logic [1:0] req, input logic acc,
                              input logic [1:0] ret, input logic v, input logic [1:0] g,
                              input int c0, input int c1, input logic ovf);
    vec_t t;
    t.rst = r; t.req = req; t.acc = acc; t.ret = ret;
    t.v = v; t.g = g; t.c0 = 5'(c0); t.c1 = 5'(c1); t.ovf = ovf;
    return t;
  endfunction

  task automatic step(input vec_t t, input string name);
    vec_t e;
    rst = t.rst; i_req = t.req; i_accept = t.acc; i_credit_ret = t.ret;
    sb.push_back(t);
    @(posedge clk);
    #1;
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $display("FAIL %s: scoreboard empty", name);
    end else begin
      e = sb.pop_front();
      if (o_valid !== e.v || o_grant !== e.g || o_credits[4:0] !== e.c0 ||
          o_credits[9:5] !== e.c1 || o_overflow !== e.ovf) begin
        errors++;
        $display("FAIL %s: got v=%0b g=%b c0=%0d c1=%0d ovf=%0b, expected v=%0b g=%b c0=%0d c1=%0d ovf=%0b",
                 name, o_valid, o_grant, o_credits[4:0], o_credits[9:5], o_overflow,
                 e.v, e.g, e.c0, e.c1, e.ovf);
      end
    end
  endtask

  initial begin
    rst = 1'b1; i_req = '0; i_accept = 1'b0; i_credit_ret = '0;
    @(posedge clk);
    step(mk(1, 2'b00, 0, 2'b00, 0, 2'b00, 31, 31, 0), "reset");

    // Round-robin with accept every cycle
    tbl.push_back(mk(0, 2'b11, 0, 2'b00, 1, 2'b01, 31, 31, 0));
    tbl.push_back(mk(0, 2'b11, 1, 2'b00, 1, 2'b10, 30, 31, 0));
    tbl.push_back(mk(0, 2'b11, 1, 2'b00, 1, 2'b01, 30, 30, 0));
    tbl.push_back(mk(0, 2'b11, 1, 2'b00, 1, 2'b10, 29, 30, 0));
    tbl.push_back(mk(0, 2'b11, 1, 2'b00, 1, 2'b01, 29, 29, 0));
    tbl.push_back(mk(0, 2'b00, 1, 2'b00, 0, 2'b00, 28, 29, 0));
    // Held grant ignores i_req changes, credit consumed only on accept
    tbl.push_back(mk(0, 2'b01, 0, 2'b00, 1, 2'b01, 28, 29, 0));
    tbl.push_back(mk(0, 2'b10, 0, 2'b00, 1, 2'b01, 28, 29, 0));
    tbl.push_back(mk(0, 2'b10, 0, 2'b00, 1, 2'b01, 28, 29, 0));
    tbl.push_back(mk(0, 2'b10, 0, 2'b00, 1, 2'b01, 28, 29, 0));
    tbl.push_back(mk(0, 2'b10, 0, 2'b00, 1, 2'b01, 28, 29, 0));
    tbl.push_back(mk(0, 2'b00, 1, 2'b00, 0, 2'b00, 27, 29, 0));
    // Refill VC1 to max, then overflow sticks
    tbl.push_back(mk(0, 2'b00, 0, 2'b10, 0, 2'b00, 27, 30, 0));
    tbl.push_back(mk(0, 2'b00, 0, 2'b10, 0, 2'b00, 27, 31, 0));
    tbl.push_back(mk(0, 2'b00, 0, 2'b10, 0, 2'b00, 27, 31, 1));
    tbl.push_back(mk(0, 2'b00, 0, 2'b00, 0, 2'b00, 27, 31, 1));
    // Pointer at 1: VC1 first; accept with simultaneous return keeps count
    tbl.push_back(mk(0, 2'b11, 0, 2'b00, 1, 2'b10, 27, 31, 1));
    tbl.push_back(mk(0, 2'b11, 1, 2'b10, 1, 2'b01, 27, 31, 1));
    tbl.push_back(mk(0, 2'b00, 1, 2'b00, 0, 2'b00, 26, 31, 1));
    // Reset during an unaccepted grant; pointer back to 0
    tbl.push_back(mk(0, 2'b01, 0, 2'b00, 1, 2'b01, 26, 31, 1));
    tbl.push_back(mk(1, 2'b11, 0, 2'b11, 0, 2'b00, 31, 31, 0));
    tbl.push_back(mk(0, 2'b11, 0, 2'b00, 1, 2'b01, 31, 31, 0));

    for (int i = 0; i < tbl.size(); i++) step(tbl[i], $sformatf("row%0d", i));

    // Drain VC0 completely
    for (int k = 1; k <= 31; k++) begin
      step(mk(0, 2'b01, 1, 2'b00, (31 - k) > 0, ((31 - k) > 0) ? 2'b01 : 2'b00,
              31 - k, 31, 0), $sformatf("drain%0d", k));
    end
    step(mk(0, 2'b01, 0, 2'b00, 0, 2'b00, 0, 31, 0), "no_credit_no_grant");
    step(mk(0, 2'b01, 0, 2'b01, 1, 2'b01, 1, 31, 0), "return_regrant");
    step(mk(0, 2'b01, 1, 2'b00, 0, 2'b00, 0, 31, 0), "redrain");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
